// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC period meter.
package rtc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } meter_state_t;

   localparam int unsigned SYS_CLK_HZ             = 1000000;
   // Two periods of the slowest 0.2 Hz divider output.
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 2 * 5 * SYS_CLK_HZ;

endpackage

// File: rtl/rtc_sync_edge.sv
// Synchronizes sig_in to sys_clk and produces single-cycle rise/fall pulses.
// Optional glitch filter: define RTC_PERIOD_METER_GLITCH_FILTER_EN.
module rtc_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;
   logic level;

   assign sync1_d = sig_in;
   assign sync2_d = sync1_q;

`ifdef RTC_PERIOD_METER_GLITCH_FILTER_EN
   logic [1:0] hist_q, hist_d;
   logic       filt_q, filt_d;

   // The level only moves once the current and two previous samples agree.
   always_comb begin
      hist_d = {hist_q[0], sync2_q};
      filt_d = filt_q;
      if (&{hist_q, sync2_q}) begin
         filt_d = 1'b1;
      end else if (~|{hist_q, sync2_q}) begin
         filt_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= hist_d;
         filt_q <= filt_d;
      end
   end

   assign level = filt_q;
`else
   assign level = sync2_q;
`endif

   assign prev_d = level;
   assign rise   = level & ~prev_q;
   assign fall   = ~level & prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

endmodule

// File: rtl/rtc_period_meter.sv
// Measures period and high time of a slow input in sys_clk cycles.
// Build option: RTC_PERIOD_METER_GLITCH_FILTER_EN enables the input glitch filter.
module rtc_period_meter
   import rtc_pkg::*;
#(
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             valid,
   input  logic             ready,
   output logic             timeout,
   output meter_state_t     dbg_state
);

   // Handshake: a result is transferred in the cycle valid && ready; valid stays
   // high and period_out/high_out/timeout stay frozen until then, and ready is
   // don't-care while valid is low.

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

   meter_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             timeout_q, timeout_d;
   logic             rise, fall;

   rtc_sync_edge u_sync_edge (
      .clk    (sys_clk),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .rise   (rise),
      .fall   (fall)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      high_d    = high_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ARM;
               cnt_d     = '0;
               period_d  = '0;
               high_d    = '0;
               timeout_d = 1'b0;
            end
         end
         ARM: begin
            if (rise) begin
               state_d = MEASURE;
               cnt_d   = CNT_W'(1);
            end else if (cnt_q == TIMEOUT_CNT) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         MEASURE: begin
            // cnt_q equals the number of cycles since the opening rise pulse.
            if (fall) begin
               high_d = cnt_q;
            end
            if (rise) begin
               state_d   = DONE;
               period_d  = cnt_q;
               timeout_d = 1'b0;
            end else if (cnt_q == TIMEOUT_CNT) begin
               state_d   = DONE;
               period_d  = TIMEOUT_CNT;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (ready) begin
               if (start) begin
                  state_d   = ARM;
                  cnt_d     = '0;
                  period_d  = '0;
                  high_d    = '0;
                  timeout_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         high_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         timeout_q <= timeout_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign valid      = (state_q == DONE);
   assign period_out = period_q;
   assign high_out   = high_q;
   assign timeout    = timeout_q;
   assign dbg_state  = state_q;

endmodule
